// File: rtl/dac_arb_pkg.sv
// Shared types and constants for the two-channel DAC arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   arb_state_t             - arbiter FSM state encoding
//   CH_A / CH_B             - values of spi_ch for DAC channels A and B
//   DEF_DATA_W/GAP_W/OVR_W  - default code, gap counter and overrun counter widths
//   rr_grant()              - round-robin pick between the two pending slots
package dac_arb_pkg;

   localparam int DEF_DATA_W = 12;
   localparam int DEF_GAP_W  = 8;
   localparam int DEF_OVR_W  = 8;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } arb_state_t;

   // With both slots pending, the channel that was not served last wins;
   // otherwise the single pending channel wins. The result is only used
   // when at least one slot is pending.
   function automatic logic rr_grant(input logic pend_a,
                                     input logic pend_b,
                                     input logic last_served);
      logic g;
      if (pend_a && pend_b) begin
         g = ~last_served;
      end else if (pend_b) begin
         g = CH_B;
      end else begin
         g = CH_A;
      end
      return g;
   endfunction

endpackage : dac_arb_pkg

// File: rtl/dac_channel_arbiter_if.sv
// Frame request bus between the channel arbiter and the serial DAC driver.
// Latency: n/a (wiring only).
// Backpressure: the driver holds spi_ready low while it is busy with a frame.
//
// Signals:
//   spi_start  - one-cycle frame start request (arbiter -> driver)
//   spi_ch     - target DAC channel, 0 = A, 1 = B (arbiter -> driver)
//   spi_data   - DAC code, stable from spi_start until spi_done (arbiter -> driver)
//   spi_ready  - driver idle and able to take a frame (driver -> arbiter)
//   spi_done   - one-cycle pulse at the end of a frame (driver -> arbiter)
interface dac_channel_arbiter_if
   import dac_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              spi_start;
   logic              spi_ch;
   logic [DATA_W-1:0] spi_data;
   logic              spi_ready;
   logic              spi_done;

   // Arbiter side.
   modport master (
      output spi_start,
      output spi_ch,
      output spi_data,
      input  spi_ready,
      input  spi_done
   );

   // DAC driver side.
   modport slave (
      input  spi_start,
      input  spi_ch,
      input  spi_data,
      output spi_ready,
      output spi_done
   );

endinterface : dac_channel_arbiter_if

// File: rtl/dac_pending_slot.sv
// One-deep pending sample slot with saturating overrun counter.
// Latency: req loads the slot and raises pend on the next qzt_clk edge.
// Backpressure: none; a newer sample always replaces an unsent one and is counted.
//
// Ports:
//   qzt_clk, reset - clock and synchronous active-high reset
//   req, data      - one-cycle sample strobe and its code
//   consume        - arbiter is taking the slot contents this cycle
//   pend           - slot holds a sample not yet handed to the arbiter
//   slot           - held sample code
//   ovr            - number of samples lost to overwrite, saturating at all-ones
module dac_pending_slot
   import dac_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OVR_W  = DEF_OVR_W
) (
   input  logic              qzt_clk,
   input  logic              reset,
   input  logic              req,
   input  logic [DATA_W-1:0] data,
   input  logic              consume,
   output logic              pend,
   output logic [DATA_W-1:0] slot,
   output logic [OVR_W-1:0]  ovr
);

   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         pend <= 1'b0;
         slot <= '0;
         ovr  <= '0;
      end else begin
         if (req) begin
            // A new sample always wins, even over a same-cycle consume:
            // the consumer has already latched the old value, so nothing
            // is lost and the slot simply stays pending.
            slot <= data;
            pend <= 1'b1;
            if (pend && !consume && (ovr != '1)) begin
               ovr <= ovr + 1'b1;
            end
         end else if (consume) begin
            pend <= 1'b0;
         end
      end
   end

endmodule : dac_pending_slot

// File: rtl/dac_channel_arbiter.sv
// Shares one serial DAC driver between two sample sources, round-robin, one frame at a time.
// Latency: strobe to spi_start is 3 cycles with the driver ready and the arbiter idle.
// Backpressure: waits in IDLE while spi_ready is low; unsent samples are overwritten and counted.
//
// Ports:
//   qzt_clk, reset   - clock and synchronous active-high reset
//   req_a, data_a    - channel A sample strobe and code
//   req_b, data_b    - channel B sample strobe and code
//   gap_cycles       - idle cycles inserted after each frame, sampled when the gap starts
//   dac              - frame request bus to the DAC driver (master side)
//   ack_a, ack_b     - one-cycle pulse on the spi_done cycle of a channel A / B frame
//   busy             - arbiter is anywhere but IDLE
//   ovr_a, ovr_b     - saturating counts of overwritten channel A / B samples
module dac_channel_arbiter
   import dac_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int GAP_W  = DEF_GAP_W,
   parameter int OVR_W  = DEF_OVR_W
) (
   input  logic                   qzt_clk,
   input  logic                   reset,
   input  logic                   req_a,
   input  logic [DATA_W-1:0]      data_a,
   input  logic                   req_b,
   input  logic [DATA_W-1:0]      data_b,
   input  logic [GAP_W-1:0]       gap_cycles,
   dac_channel_arbiter_if.master  dac,
   output logic                   ack_a,
   output logic                   ack_b,
   output logic                   busy,
   output logic [OVR_W-1:0]       ovr_a,
   output logic [OVR_W-1:0]       ovr_b
);

   arb_state_t        state;
   arb_state_t        state_nxt;

   logic              grant;        // channel chosen in IDLE, used in LOAD
   logic              last_served;  // channel of the most recent frame
   logic [GAP_W-1:0]  gap_cnt;      // remaining GAP cycles

   logic              spi_ch_q;
   logic [DATA_W-1:0] spi_data_q;

   logic              pend_a;
   logic              pend_b;
   logic [DATA_W-1:0] slot_a;
   logic [DATA_W-1:0] slot_b;
   logic              consume_a;
   logic              consume_b;

   logic              spi_start_c;
   logic              ack_a_c;
   logic              ack_b_c;
   logic              busy_c;

   // ------------------------------------------------------------------
   // Pending slots
   // ------------------------------------------------------------------
   assign consume_a = (state == LOAD) && (grant == CH_A);
   assign consume_b = (state == LOAD) && (grant == CH_B);

   dac_pending_slot #(
      .DATA_W (DATA_W),
      .OVR_W  (OVR_W)
   ) u_slot_a (
      .qzt_clk (qzt_clk),
      .reset   (reset),
      .req     (req_a),
      .data    (data_a),
      .consume (consume_a),
      .pend    (pend_a),
      .slot    (slot_a),
      .ovr     (ovr_a)
   );

   dac_pending_slot #(
      .DATA_W (DATA_W),
      .OVR_W  (OVR_W)
   ) u_slot_b (
      .qzt_clk (qzt_clk),
      .reset   (reset),
      .req     (req_b),
      .data    (data_b),
      .consume (consume_b),
      .pend    (pend_b),
      .slot    (slot_b),
      .ovr     (ovr_b)
   );

   // ------------------------------------------------------------------
   // FSM: next state and decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      spi_start_c = 1'b0;
      ack_a_c     = 1'b0;
      ack_b_c     = 1'b0;
      busy_c      = (state != IDLE);

      case (state)
         IDLE: begin
            if ((pend_a || pend_b) && dac.spi_ready) begin
               state_nxt = LOAD;
            end
         end

         LOAD: begin
            state_nxt = START;
         end

         START: begin
            spi_start_c = 1'b1;
            state_nxt   = WAIT_DONE;
         end

         WAIT_DONE: begin
            // spi_ch_q already holds this frame's channel, so the ack
            // steers from it rather than from grant.
            if (dac.spi_done) begin
               ack_a_c   = (spi_ch_q == CH_A);
               ack_b_c   = (spi_ch_q == CH_B);
               state_nxt = (gap_cycles != '0) ? GAP : IDLE;
            end
         end

         GAP: begin
            if (gap_cnt == GAP_W'(1)) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM state and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= CH_A;
         last_served <= CH_B;  // so channel A takes the first tie
         gap_cnt     <= '0;
         spi_ch_q    <= CH_A;
         spi_data_q  <= '0;
      end else begin
         state <= state_nxt;

         // Freeze the winner at the IDLE decision so a late strobe on the
         // other channel cannot change which slot LOAD consumes.
         if (state == IDLE) begin
            grant <= rr_grant(pend_a, pend_b, last_served);
         end

         if (state == LOAD) begin
            spi_ch_q    <= grant;
            spi_data_q  <= (grant == CH_B) ? slot_b : slot_a;
            last_served <= grant;
         end

         // The gap length is captured once, on entry, so a change to
         // gap_cycles during a gap only affects the next one.
         if ((state == WAIT_DONE) && dac.spi_done) begin
            gap_cnt <= gap_cycles;
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign dac.spi_start = spi_start_c;
   assign dac.spi_ch    = spi_ch_q;
   assign dac.spi_data  = spi_data_q;
   assign ack_a         = ack_a_c;
   assign ack_b         = ack_b_c;
   assign busy          = busy_c;

endmodule : dac_channel_arbiter

// File: tb/tb_dac_channel_arbiter.sv
// Self-checking bench for dac_channel_arbiter: directed scenarios plus a random phase,
// predicted by a cycle-timed queue model of the arbiter; a monitor checks every frame
// start and ack against the predicted queues.
module tb_dac_channel_arbiter;
   import dac_arb_pkg::*;

   localparam int DW  = 12;
   localparam int GW  = 8;
   localparam int OW  = 8;
   localparam int BIG = 32'h7fff_ffff;

   typedef struct {
      int              cyc;
      logic            ch;
      logic [DW-1:0]   data;
   } exp_t;

   logic          qzt_clk = 1'b0;
   logic          reset   = 1'b1;
   logic          req_a   = 1'b0;
   logic [DW-1:0] data_a  = '0;
   logic          req_b   = 1'b0;
   logic [DW-1:0] data_b  = '0;
   logic [GW-1:0] gap_cycles = '0;
   logic          ack_a;
   logic          ack_b;
   logic          busy;
   logic [OW-1:0] ovr_a;
   logic [OW-1:0] ovr_b;

   dac_channel_arbiter_if #(.DATA_W(DW)) dac ();

   dac_channel_arbiter #(
      .DATA_W (DW),
      .GAP_W  (GW),
      .OVR_W  (OW)
   ) dut (
      .qzt_clk    (qzt_clk),
      .reset      (reset),
      .req_a      (req_a),
      .data_a     (data_a),
      .req_b      (req_b),
      .data_b     (data_b),
      .gap_cycles (gap_cycles),
      .dac        (dac),
      .ack_a      (ack_a),
      .ack_b      (ack_b),
      .busy       (busy),
      .ovr_a      (ovr_a),
      .ovr_b      (ovr_b)
   );

   always #5 qzt_clk = ~qzt_clk;

   int cyc = 0;
   always @(posedge qzt_clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // DAC driver model: ready when idle, spi_done frame_len cycles after spi_start
   // ------------------------------------------------------------------
   int frame_len  = 16;
   bit ready_en   = 1'b1;
   bit force_done = 1'b0;
   bit act        = 1'b0;
   int k          = 0;

   initial begin
      dac.spi_ready = 1'b0;
      dac.spi_done  = 1'b0;
      forever begin
         @(posedge qzt_clk);
         #1;
         dac.spi_done = 1'b0;
         if (reset) begin
            act = 1'b0;
            k   = 0;
         end else begin
            if (act) begin
               k++;
               if (k == frame_len) dac.spi_done = 1'b1;
               else if (k > frame_len) act = 1'b0;
            end
            if (dac.spi_start && !act) begin
               act = 1'b1;
               k   = 0;
            end
         end
         if (force_done) dac.spi_done = 1'b1;
         dac.spi_ready = ready_en && !act;
      end
   end

   // ------------------------------------------------------------------
   // Reference model: one pending value per channel, a "free from" cycle
   // for the shared driver, and the 3-cycle decide/load/start pipeline.
   // ------------------------------------------------------------------
   exp_t          sq[$];        // predicted frame starts
   exp_t          aq[$];        // predicted acks
   bit            m_pend[2];
   logic [DW-1:0] m_val[2];
   int            m_ovr[2];
   bit            m_last    = 1'b1;
   bit            m_g       = 1'b0;
   int            next_idle = 0;
   int            load_at   = -1;
   int            done_at   = -1;

   initial begin
      forever begin
         exp_t          e;
         bit            rq[2];
         logic [DW-1:0] rd[2];
         @(negedge qzt_clk);
         #2;
         rq[0] = req_a;  rd[0] = data_a;
         rq[1] = req_b;  rd[1] = data_b;
         if (reset) begin
            for (int c = 0; c < 2; c++) begin
               m_pend[c] = 1'b0;
               m_val[c]  = '0;
               m_ovr[c]  = 0;
            end
            m_last    = 1'b1;
            next_idle = cyc + 1;
            load_at   = -1;
            done_at   = -1;
            sq.delete();
            aq.delete();
         end else begin
            if (cyc == done_at) next_idle = cyc + 1 + int'(gap_cycles);
            if (cyc == load_at) begin
               e.cyc  = cyc + 1;
               e.ch   = m_g;
               e.data = m_val[m_g];
               sq.push_back(e);
               m_pend[m_g] = 1'b0;
            end
            // Decision sees the pending state from before this cycle's strobes.
            if (cyc >= next_idle && (m_pend[0] || m_pend[1]) && dac.spi_ready) begin
               if (m_pend[0] && m_pend[1]) m_g = !m_last;
               else                        m_g = m_pend[1];
               m_last    = m_g;
               load_at   = cyc + 1;
               done_at   = cyc + 2 + frame_len;
               next_idle = BIG;
               e.cyc  = done_at;
               e.ch   = m_g;
               e.data = '0;
               aq.push_back(e);
            end
            for (int c = 0; c < 2; c++) begin
               if (rq[c]) begin
                  if (m_pend[c]) m_ovr[c] = (m_ovr[c] < 255) ? m_ovr[c] + 1 : 255;
                  m_pend[c] = 1'b1;
                  m_val[c]  = rd[c];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Monitor: compares every spi_start and ack with the predicted queues
   // ------------------------------------------------------------------
   exp_t          start_log[$];
   logic [DW-1:0] fr_data = '0;

   initial begin
      forever begin
         exp_t e;
         @(negedge qzt_clk);
         if (sq.size() > 0 && sq[0].cyc < cyc) begin
            chk("start_missing", cyc, sq[0].cyc);
            void'(sq.pop_front());
         end
         if (aq.size() > 0 && aq[0].cyc < cyc) begin
            chk("ack_missing", cyc, aq[0].cyc);
            void'(aq.pop_front());
         end
         if (dac.spi_start) begin
            e.cyc  = cyc;
            e.ch   = dac.spi_ch;
            e.data = dac.spi_data;
            start_log.push_back(e);
            fr_data = dac.spi_data;
            chk("start_expected", int'(sq.size() > 0), 1);
            if (sq.size() > 0) begin
               e = sq.pop_front();
               chk("start_cycle", cyc, e.cyc);
               chk("start_ch", dac.spi_ch, e.ch);
               chk("start_data", dac.spi_data, e.data);
            end
         end
         if (ack_a || ack_b) begin
            chk("ack_expected", int'(aq.size() > 0), 1);
            chk("ack_onehot", int'(ack_a && ack_b), 0);
            chk("data_stable", dac.spi_data, fr_data);
            if (aq.size() > 0) begin
               e = aq.pop_front();
               chk("ack_cycle", cyc, e.cyc);
               chk("ack_ch", ack_b, e.ch);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge qzt_clk);
         #2;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_spi_start"}, dac.spi_start, 0);
      chk({tag, "_spi_ch"},    dac.spi_ch,    0);
      chk({tag, "_spi_data"},  dac.spi_data,  0);
      chk({tag, "_ack"},       {ack_a, ack_b}, 0);
      chk({tag, "_busy"},      busy,          0);
      chk({tag, "_ovr_a"},     ovr_a,         0);
      chk({tag, "_ovr_b"},     ovr_b,         0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
   endtask

   task automatic check_ovr(input string tag);
      chk({tag, "_ovr_a"}, ovr_a, m_ovr[0]);
      chk({tag, "_ovr_b"}, ovr_b, m_ovr[1]);
   endtask

   task automatic drain(input string tag);
      int w = 0;
      while (!(sq.size() == 0 && aq.size() == 0 && !busy && !m_pend[0] && !m_pend[1])
             && w < 3000) begin
         tick();
         w++;
      end
      chk({tag, "_drained"},
          int'(sq.size() == 0 && aq.size() == 0 && !busy && !m_pend[0] && !m_pend[1]), 1);
   endtask

   task automatic strobe(input bit a, input logic [DW-1:0] da,
                         input bit b, input logic [DW-1:0] db);
      req_a = a;  data_a = da;
      req_b = b;  data_b = db;
      tick();
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   initial begin
      int c0;
      int w;

      // Reset state
      do_reset(3);
      check_zero_outputs("reset");

      // Single A: 3-cycle latency, ack on spi_done, busy drops afterwards
      strobe(1'b1, 12'hABC, 1'b0, '0);
      drain("single_a");
      chk("single_a_frames", start_log.size(), 1);
      if (start_log.size() > 0) chk("single_a_data", start_log[0].data, 12'hABC);

      // Tie after reset: A then B, spaced by frame + 3
      do_reset(1);
      start_log.delete();
      strobe(1'b1, 12'h111, 1'b1, 12'h222);
      drain("tie");
      chk("tie_frames", start_log.size(), 2);
      if (start_log.size() == 2) begin
         chk("tie_first_ch", start_log[0].ch, CH_A);
         chk("tie_spacing", start_log[1].cyc - start_log[0].cyc, frame_len + 3);
      end

      // Fairness: both channels strobe every cycle
      start_log.delete();
      for (int i = 0; i < 200; i++) begin
         req_a = 1'b1;  data_a = DW'($urandom);
         req_b = 1'b1;  data_b = DW'($urandom);
         tick();
      end
      req_a = 1'b0;
      req_b = 1'b0;
      drain("fair");
      chk("fair_enough_frames", int'(start_log.size() >= 10), 1);
      for (int i = 1; i < 10 && i < start_log.size(); i++) begin
         chk("fair_alternate", start_log[i].ch, !start_log[i-1].ch);
      end
      check_ovr("fair");

      // Overrun while the driver is stalled, then saturation
      do_reset(1);
      ready_en = 1'b0;
      tick(2);
      for (int i = 1; i <= 5; i++) strobe(1'b0, '0, 1'b1, DW'(i));
      tick();
      chk("ovr_b_after_5", ovr_b, 4);
      check_ovr("ovr5");
      start_log.delete();
      ready_en = 1'b1;
      drain("ovr5");
      chk("ovr5_frames", start_log.size(), 1);
      if (start_log.size() > 0) chk("ovr5_data", start_log[0].data, 12'h005);
      ready_en = 1'b0;
      tick(2);
      for (int i = 0; i < 300; i++) strobe(1'b0, '0, 1'b1, DW'($urandom));
      tick();
      chk("ovr_b_saturated", ovr_b, 8'hFF);
      check_ovr("ovr_sat");
      ready_en = 1'b1;
      drain("ovr_sat");

      // Same-cycle strobe on LOAD, with a gap
      gap_cycles = 8'd10;
      start_log.delete();
      strobe(1'b1, 12'h3C3, 1'b0, '0);   // idle decision next cycle, LOAD the one after
      tick();
      strobe(1'b1, 12'h0F0, 1'b0, '0);   // lands on the LOAD cycle
      drain("same_cycle");
      chk("same_cycle_frames", start_log.size(), 2);
      if (start_log.size() == 2) begin
         chk("same_cycle_first",  start_log[0].data, 12'h3C3);
         chk("same_cycle_second", start_log[1].data, 12'h0F0);
         chk("same_cycle_spacing", start_log[1].cyc - start_log[0].cyc, frame_len + 3 + 10);
      end
      check_ovr("same_cycle");

      // Reset during WAIT_DONE: no ack, outputs cleared, later spi_done ignored
      gap_cycles = '0;
      strobe(1'b1, 12'h5A5, 1'b1, 12'h777);
      w = 0;
      while (!dac.spi_start && w < 50) begin
         tick();
         w++;
      end
      chk("midreset_started", dac.spi_start, 1);
      tick(5);
      do_reset(1);
      check_zero_outputs("midreset");
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      chk("stray_done_seen", dac.spi_done, 1);
      chk("stray_done_ack", {ack_a, ack_b}, 0);
      chk("stray_done_busy", busy, 0);
      tick(3);

      // Random traffic with stalls, varying gaps and a short frame
      frame_len = 5;
      c0 = cyc;
      for (int i = 0; i < 1500; i++) begin
         req_a  = ($urandom_range(0, 3) == 0);
         data_a = DW'($urandom);
         req_b  = ($urandom_range(0, 4) == 0);
         data_b = DW'($urandom);
         if ($urandom_range(0, 40) == 0) gap_cycles = GW'($urandom_range(0, 6));
         if ($urandom_range(0, 30) == 0) ready_en = !ready_en;
         tick();
         if (i % 250 == 0) check_ovr("rand");
      end
      req_a = 1'b0;
      req_b = 1'b0;
      ready_en = 1'b1;
      drain("rand");
      check_ovr("rand_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)",
               n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_dac_channel_arbiter

// File: doc/dac_channel_arbiter.md
Name: dac_channel_arbiter

Overview:
- Shares the single serial DAC driver (channels A and B, 12-bit codes) between two independent waveform sources.
- Each source posts samples with a one-cycle strobe. The arbiter holds each posted sample in a per-channel pending slot.
- Pending slots are served round-robin, one SPI transaction at a time, with a programmable inter-frame gap.
- Sits between the waveform counters/generators and the DAC SPI driver in the waveform-generator top level.

Parameters:
- DATA_W, 12, DAC code width.
- GAP_W, 8, width of the inter-frame gap counter.
- OVR_W, 8, width of each saturating overrun counter.

Ports:
- qzt_clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- req_a  in  1  channel A sample strobe, one cycle.
- data_a  in  DATA_W  channel A sample, valid with req_a.
- req_b  in  1  channel B sample strobe, one cycle.
- data_b  in  DATA_W  channel B sample, valid with req_b.
- gap_cycles  in  GAP_W  idle qzt_clk cycles inserted after each transaction.
- spi_ready  in  1  DAC driver idle and able to accept a frame.
- spi_done  in  1  one-cycle pulse at the end of a DAC frame.
- spi_start  out  1  one-cycle frame start request.
- spi_ch  out  1  target channel: 0 = A, 1 = B.
- spi_data  out  DATA_W  code for the frame; stable from spi_start until spi_done.
- ack_a  out  1  one-cycle pulse when a channel A frame completes.
- ack_b  out  1  one-cycle pulse when a channel B frame completes.
- busy  out  1  high in every state except IDLE.
- ovr_a  out  OVR_W  count of channel A samples overwritten before being sent (saturating).
- ovr_b  out  OVR_W  count of channel B samples overwritten before being sent (saturating).

Behaviour:
- Reset (synchronous, checked first in the qzt_clk process):
  - FSM goes to IDLE; pending flags clear; slot data clears to 0.
  - Outputs after reset: spi_start=0, spi_ch=0, spi_data=0, ack_a=ack_b=0, busy=0, ovr_a=ovr_b=0.
  - last_served=1 after reset, so channel A wins the first tie.
  - Reset asserted mid-transaction abandons that transaction with no ack. The DAC driver shares the same reset.
- Pending slot, one per channel:
  - req_x=1 loads data_x into the slot and sets pend_x.
  - If pend_x is already 1 and the slot is not being consumed that cycle, the old value is lost. ovr_x increments, saturating at all-ones.
  - A req_x arriving in the same cycle the slot is consumed (LOAD) wins: pend_x stays 1, the slot takes the new data, ovr_x is unchanged.
- FSM states: IDLE, LOAD, START, WAIT_DONE, GAP.
  - IDLE: if (pend_a | pend_b) & spi_ready, go to LOAD.
    - Grant: the only pending channel, or if both are pending, the channel != last_served.
  - LOAD: spi_ch <= grant; spi_data <= slot[grant]; pend[grant] cleared (subject to the same-cycle req rule); last_served <= grant. Go to START.
  - START: spi_start=1 for exactly this cycle. Go to WAIT_DONE.
  - WAIT_DONE: hold spi_ch and spi_data. On spi_done, pulse ack_<grant> for one cycle.
    - Then go to GAP if gap_cycles != 0, otherwise to IDLE.
    - No timeout: the driver guarantees spi_done.
  - GAP: count gap_cycles cycles, then go to IDLE. gap_cycles is sampled on GAP entry.
- Latency, strobe to spi_start, with the driver ready and the arbiter idle: req at cycle 0, slot valid at cycle 1 (IDLE sees pend), LOAD at cycle 2, spi_start at cycle 3.
- Minimum spacing between spi_start pulses: frame length + 3 + gap_cycles.
- spi_done outside WAIT_DONE is ignored.
- spi_ready low in IDLE stalls the FSM; pending samples keep updating and counting overruns.
- busy = (state != IDLE).

Decomposition:
- Package dac_arb_pkg holds:
  - the state enum (IDLE, LOAD, START, WAIT_DONE, GAP);
  - channel constants CH_A=0 and CH_B=1;
  - the default DATA_W, GAP_W and OVR_W values.
- Sub-module dac_pending_slot: data register, pend flag, consume input and saturating overrun counter. Instantiated once per channel.
- The top module holds the FSM, the round-robin grant and the output registers.

Test Plan:
- Single A: gap_cycles=0, spi_ready=1, req_a with 12'hABC; model driver returns spi_done 16 cycles after spi_start.
  -> spi_start 3 cycles after req, spi_ch=0, spi_data=12'hABC; ack_a on the spi_done cycle; busy returns to 0.
- Tie: req_a(12'h111) and req_b(12'h222) in the same cycle after reset.
  -> A is sent first, then B; two spi_start pulses, with the second one frame length + 3 cycles after the first.
- Round-robin fairness: both channels strobe every cycle for 10 frames.
  -> spi_ch alternates 0,1,0,1,...; the channel values sent are the latest strobed values.
- Overrun: spi_ready=0; strobe req_b 5 times with 1,2,3,4,5; then raise spi_ready.
  -> one B frame carrying 12'h005; ovr_b=4. 300 further stalled strobes saturate ovr_b at 8'hFF.
- Same-cycle rule and gap: gap_cycles=10; req_a(12'h0F0) lands on the LOAD cycle of an earlier A sample.
  -> earlier value sent; pend_a remains set; 12'h0F0 sent next; spacing = frame + 3 + 10 cycles.
- Reset mid-frame: assert reset for 1 cycle during WAIT_DONE.
  -> no ack; all outputs and ovr counters are 0 the next cycle; a later spi_done is ignored.
